pcap_frame_sequencer: RTL and testbench

Front-end controller that sequences a raw PCAP byte stream into per-packet frames for the UDP parser. Reads bytes from the input FIFO, skips the 24-byte PCAP global header, decodes each 16-byte record header to get the captured length, and forwards exactly that many bytes into the parser-side FIFO. Flags the first byte with SOF and the last with EOF. Sits between the file-loader FIFO and `udp_parser`'s input FIFO.

---
 rtl/udp_pkg.sv | 22 ++
 rtl/pcap_frame_sequencer.sv | 146 ++++++++++++++
 tb/tb_pcap_frame_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared PCAP/UDP front-end types and constants
package udp_pkg;

    typedef enum logic [2:0] {
        GLOBAL_HDR,
        REC_HDR,
        PAYLOAD,
        DROP,
        ERROR
    } pcap_seq_state_t;

    localparam logic [31:0] PCAP_MAGIC           = 32'ha1b2c3d4;
    localparam int          PCAP_INCL_LEN_OFFSET = 8;
    localparam int          PCAP_GLOBAL_HDR_LEN  = 24;
    localparam int          PCAP_REC_HDR_LEN     = 16;

    // Magic appears on the wire little-endian: d4 c3 b2 a1.
    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        return PCAP_MAGIC[8*idx +: 8];
    endfunction

endpackage

// File: rtl/pcap_frame_sequencer.sv
// rtl/pcap_frame_sequencer.sv - PCAP byte stream to SOF/EOF framed packets (optional PCAP_MAGIC_CHECK_EN)
module pcap_frame_sequencer
    import udp_pkg::*;
#(
    parameter int PCAP_HEADER_BYTES      = PCAP_GLOBAL_HDR_LEN,
    parameter int PCAP_DATA_HEADER_BYTES = PCAP_REC_HDR_LEN,
    parameter int DATA_WIDTH             = 8,
    parameter int MAX_FRAME_BYTES        = 2048,
    parameter int CNT_WIDTH              = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic                  error
);

    localparam int HCW = 8;

    pcap_seq_state_t r_state;
    pcap_seq_state_t w_next_state;
    logic [HCW-1:0]       r_hdr_cnt;
    logic [31:0]          r_incl_len;
    logic [31:0]          r_remaining;
    logic [CNT_WIDTH-1:0] r_frame_count;
    logic [CNT_WIDTH-1:0] r_drop_count;
    logic                 w_hdr_last;
    logic                 w_len_zero;
    logic                 w_len_big;

    assign w_hdr_last = (r_state == GLOBAL_HDR) ? (r_hdr_cnt == HCW'(PCAP_HEADER_BYTES - 1))
                                                : (r_hdr_cnt == HCW'(PCAP_DATA_HEADER_BYTES - 1));
    assign w_len_zero = (r_incl_len == 32'd0);
    assign w_len_big  = (r_incl_len > 32'(MAX_FRAME_BYTES));

    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;

`ifdef PCAP_MAGIC_CHECK_EN
    logic r_error;
    logic w_magic_bad;

    assign w_magic_bad = (r_state == GLOBAL_HDR) && (r_hdr_cnt < HCW'(4)) &&
                         (din[7:0] != magic_byte(r_hdr_cnt[1:0]));
    assign error       = r_error;
`else
    assign error = 1'b0;
`endif

    // Next-state and combinational handshake/data outputs
    always_comb begin
        w_next_state = r_state;
        in_rd_en     = 1'b0;
        out_wr_en    = 1'b0;
        out_din      = '0;
        out_sof      = 1'b0;
        out_eof      = 1'b0;
        case (r_state)
            GLOBAL_HDR: begin
                in_rd_en = !empty && !reset;
                if (in_rd_en && w_hdr_last) w_next_state = REC_HDR;
`ifdef PCAP_MAGIC_CHECK_EN
                if (in_rd_en && w_magic_bad) w_next_state = ERROR;
`endif
            end
            REC_HDR: begin
                in_rd_en = !empty && !reset;
                if (in_rd_en && w_hdr_last) begin
                    if (w_len_zero)     w_next_state = REC_HDR;
                    else if (w_len_big) w_next_state = DROP;
                    else                w_next_state = PAYLOAD;
                end
            end
            PAYLOAD: begin
                out_wr_en = !empty && !out_full && !reset;
                in_rd_en  = out_wr_en;
                if (out_wr_en) begin
                    out_din = din;
                    out_sof = (r_remaining == r_incl_len);
                    out_eof = (r_remaining == 32'd1);
                    if (r_remaining == 32'd1) w_next_state = REC_HDR;
                end
            end
            DROP: begin
                in_rd_en = !empty && !reset;
                if (in_rd_en && r_remaining == 32'd1) w_next_state = REC_HDR;
            end
            default: w_next_state = r_state;
        endcase
    end

    // State, header index, length capture and counters
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= GLOBAL_HDR;
            r_hdr_cnt     <= '0;
            r_incl_len    <= '0;
            r_remaining   <= '0;
            r_frame_count <= '0;
            r_drop_count  <= '0;
        end else begin
            r_state <= w_next_state;
            if (in_rd_en) begin
                case (r_state)
                    GLOBAL_HDR, REC_HDR: begin
                        r_hdr_cnt <= w_hdr_last ? '0 : r_hdr_cnt + HCW'(1);
                        if (r_state == REC_HDR) begin
                            if (r_hdr_cnt == HCW'(PCAP_INCL_LEN_OFFSET + 0)) r_incl_len[7:0]   <= din[7:0];
                            if (r_hdr_cnt == HCW'(PCAP_INCL_LEN_OFFSET + 1)) r_incl_len[15:8]  <= din[7:0];
                            if (r_hdr_cnt == HCW'(PCAP_INCL_LEN_OFFSET + 2)) r_incl_len[23:16] <= din[7:0];
                            if (r_hdr_cnt == HCW'(PCAP_INCL_LEN_OFFSET + 3)) r_incl_len[31:24] <= din[7:0];
                            if (w_hdr_last) begin
                                r_remaining <= r_incl_len;
                                if (w_len_big && r_drop_count != '1)
                                    r_drop_count <= r_drop_count + CNT_WIDTH'(1);
                            end
                        end
                    end
                    PAYLOAD, DROP: begin
                        r_remaining <= r_remaining - 32'd1;
                        if (r_state == PAYLOAD && r_remaining == 32'd1 && r_frame_count != '1)
                            r_frame_count <= r_frame_count + CNT_WIDTH'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PCAP_MAGIC_CHECK_EN
    // Sticky bad-magic flag
    always_ff @(posedge clock) begin
        if (reset)                      r_error <= 1'b0;
        else if (in_rd_en && w_magic_bad) r_error <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_pcap_frame_sequencer.sv
// tb/tb_pcap_frame_sequencer.sv - scoreboard bench for pcap_frame_sequencer
module tb_pcap_frame_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  din = 8'h00;
    logic        empty = 1'b1;
    logic        in_rd_en;
    logic [7:0]  out_din;
    logic        out_sof;
    logic        out_eof;
    logic        out_wr_en;
    logic        out_full = 1'b0;
    logic [15:0] frame_count;
    logic [15:0] drop_count;
    logic        error;

    int checks = 0;
    int errors = 0;
    int n_writes, n_pops, n_viol;

    logic [7:0] in_q[$];
    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];

    pcap_frame_sequencer dut (
        .clock(clock), .reset(reset), .din(din), .empty(empty), .in_rd_en(in_rd_en),
        .out_din(out_din), .out_sof(out_sof), .out_eof(out_eof), .out_wr_en(out_wr_en),
        .out_full(out_full), .frame_count(frame_count), .drop_count(drop_count), .error(error)
    );

    always #5 clock = ~clock;

    task automatic push_global(input bit bad_magic);
        in_q.push_back(8'hd4);
        in_q.push_back(8'hc3);
        in_q.push_back(8'hb2);
        in_q.push_back(bad_magic ? 8'h00 : 8'ha1);
        for (int i = 0; i < 20; i++) in_q.push_back(8'($urandom_range(255)));
    endtask

    task automatic push_record(input int len);
        logic [31:0] l;
        logic [7:0]  b;
        l = 32'(len);
        for (int i = 0; i < 8; i++) in_q.push_back(8'($urandom_range(255)));
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) in_q.push_back(l[8*i +: 8]);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(255));
            in_q.push_back(b);
            if (len <= 2048) exp_q.push_back({b, i == 0, i == len - 1});
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; empty = 1'b1; out_full = 1'b0; din = 8'h00;
        in_q.delete(); exp_q.delete(); obs_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Plays in_q as a first-word-fall-through FIFO and records every write.
    task automatic run_stream(input int max_cycles, input int full_pct, input int stop_writes);
        n_writes = 0; n_pops = 0; n_viol = 0;
        obs_q.delete();
        for (int c = 0; ; c++) begin
            @(negedge clock);
            if (in_q.size() == 0 || n_writes >= stop_writes || c >= max_cycles) begin
                empty = 1'b1; out_full = 1'b0; din = 8'h00;
                break;
            end
            empty    = 1'b0;
            din      = in_q[0];
            out_full = ($urandom_range(99) < full_pct);
            #1;
            if (out_wr_en) begin
                obs_q.push_back({out_din, out_sof, out_eof});
                n_writes++;
                if (out_full || !in_rd_en) n_viol++;
            end else if (out_sof || out_eof || out_din != 8'h00) begin
                n_viol++;
            end
            if (in_rd_en) begin
                void'(in_q.pop_front());
                n_pops++;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; empty = 1'b0; din = 8'h5a;
        @(negedge clock);
        #1;
        checks++;
        if (in_rd_en !== 1'b0 || out_wr_en !== 1'b0) begin
            errors++; $display("FAIL reset_handshake: rd=%b wr=%b expected 0 0", in_rd_en, out_wr_en);
        end
        checks++;
        if (frame_count !== 16'd0 || drop_count !== 16'd0 || error !== 1'b0) begin
            errors++; $display("FAIL reset_counters: fc=%0d dc=%0d err=%b expected 0 0 0", frame_count, drop_count, error);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        push_global(1'b0);
        push_record(60);
        run_stream(1000, 0, 1 << 30);
        checks++;
        if (in_q.size() !== 0) begin errors++; $display("FAIL single_drain: left %0d bytes expected 0", in_q.size()); end
        checks++;
        if (obs_q.size() !== 60) begin errors++; $display("FAIL single_writes: got %0d expected 60", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (frame_count !== 16'd1 || drop_count !== 16'd0) begin
            errors++; $display("FAIL single_counts: fc=%0d dc=%0d expected 1 0", frame_count, drop_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_global(1'b0);
        push_record(42);
        push_record(1);
        run_stream(1000, 0, 1 << 30);
        checks++;
        if (obs_q.size() !== 43) begin errors++; $display("FAIL b2b_writes: got %0d expected 43", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (obs_q.size() == 43 && obs_q[42][1:0] !== 2'b11) begin
            errors++; $display("FAIL b2b_single_flags: got %b expected 11", obs_q[42][1:0]);
        end
        checks++;
        if (frame_count !== 16'd2) begin errors++; $display("FAIL b2b_fc: got %0d expected 2", frame_count); end
    endtask

    task automatic test_zero_len();
        do_reset();
        push_global(1'b0);
        push_record(0);
        push_record(5);
        run_stream(1000, 0, 1 << 30);
        checks++;
        if (in_q.size() !== 0 || obs_q.size() !== 5) begin
            errors++; $display("FAIL zero_len_writes: left %0d writes %0d expected 0 5", in_q.size(), obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL zero_len_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (frame_count !== 16'd1) begin errors++; $display("FAIL zero_len_fc: got %0d expected 1", frame_count); end
    endtask

    task automatic test_drop();
        do_reset();
        push_global(1'b0);
        push_record(3000);
        push_record(64);
        run_stream(5000, 0, 1 << 30);
        checks++;
        if (in_q.size() !== 0) begin errors++; $display("FAIL drop_drain: left %0d bytes expected 0", in_q.size()); end
        checks++;
        if (obs_q.size() !== 64) begin errors++; $display("FAIL drop_writes: got %0d expected 64", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL drop_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (drop_count !== 16'd1 || frame_count !== 16'd1) begin
            errors++; $display("FAIL drop_counts: fc=%0d dc=%0d expected 1 1", frame_count, drop_count);
        end
    endtask

    task automatic test_max_len();
        do_reset();
        push_global(1'b0);
        push_record(2048);
        push_record(2049);
        run_stream(6000, 0, 1 << 30);
        checks++;
        if (in_q.size() !== 0 || obs_q.size() !== 2048) begin
            errors++; $display("FAIL maxlen_writes: left %0d writes %0d expected 0 2048", in_q.size(), obs_q.size());
        end
        checks++;
        if (obs_q.size() == 2048 && (obs_q[0] !== exp_q[0] || obs_q[2047] !== exp_q[2047])) begin
            errors++; $display("FAIL maxlen_ends: got %h %h expected %h %h", obs_q[0], obs_q[2047], exp_q[0], exp_q[2047]);
        end
        checks++;
        if (frame_count !== 16'd1 || drop_count !== 16'd1) begin
            errors++; $display("FAIL maxlen_counts: fc=%0d dc=%0d expected 1 1", frame_count, drop_count);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        push_global(1'b0);
        push_record(100);
        run_stream(2000, 30, 1 << 30);
        checks++;
        if (in_q.size() !== 0 || n_pops !== 140) begin
            errors++; $display("FAIL bp_pops: left %0d pops %0d expected 0 140", in_q.size(), n_pops);
        end
        checks++;
        if (n_viol !== 0) begin errors++; $display("FAIL bp_handshake: got %0d violations expected 0", n_viol); end
        checks++;
        if (obs_q.size() !== 100) begin errors++; $display("FAIL bp_writes: got %0d expected 100", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_magic();
        do_reset();
        push_global(1'b1);
        push_record(10);
`ifdef PCAP_MAGIC_CHECK_EN
        run_stream(80, 0, 1 << 30);
        checks++;
        if (n_pops !== 4 || n_writes !== 0) begin
            errors++; $display("FAIL magic_pops: pops %0d writes %0d expected 4 0", n_pops, n_writes);
        end
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL magic_error: got %b expected 1", error); end
        empty = 1'b0; din = in_q[0];
        #1;
        checks++;
        if (in_rd_en !== 1'b0) begin errors++; $display("FAIL magic_absorb: rd=%b expected 0", in_rd_en); end
        empty = 1'b1;
`else
        run_stream(200, 0, 1 << 30);
        checks++;
        if (in_q.size() !== 0 || obs_q.size() !== 10) begin
            errors++; $display("FAIL nomagic_writes: left %0d writes %0d expected 0 10", in_q.size(), obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL nomagic_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (error !== 1'b0 || frame_count !== 16'd1) begin
            errors++; $display("FAIL nomagic_status: err=%b fc=%0d expected 0 1", error, frame_count);
        end
`endif
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        push_global(1'b0);
        push_record(8);
        push_record(2500);
        push_record(60);
        run_stream(5000, 0, 28);
        checks++;
        if (n_writes !== 28 || frame_count !== 16'd1 || drop_count !== 16'd1) begin
            errors++; $display("FAIL midreset_pre: writes %0d fc=%0d dc=%0d expected 28 1 1", n_writes, frame_count, drop_count);
        end
        do_reset();
        #1;
        checks++;
        if (frame_count !== 16'd0 || drop_count !== 16'd0 || out_wr_en !== 1'b0) begin
            errors++; $display("FAIL midreset_clear: fc=%0d dc=%0d wr=%b expected 0 0 0", frame_count, drop_count, out_wr_en);
        end
        push_global(1'b0);
        push_record(10);
        run_stream(500, 0, 1 << 30);
        checks++;
        if (obs_q.size() !== 10) begin errors++; $display("FAIL midreset_writes: got %0d expected 10", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL midreset_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (frame_count !== 16'd1) begin errors++; $display("FAIL midreset_fc: got %0d expected 1", frame_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_len();
        test_drop();
        test_max_len();
        test_backpressure();
        test_magic();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
